pcileech_com_rx_dispatch: RTL
=============================

# pcileech_com_rx_dispatch

Decodes the 64-bit command word stream delivered by the communication core (`dfifo.com_dout` / `dfifo.com_dout_valid`, clk domain) and routes each word to one of three consumers: the TLP path, the config/DRP path, and the FIFO command-register path. It tracks TLP packet framing with a length limit and an inactivity timeout. It flags malformed words. The input has no backpressure, so every output is a valid-only pulse that the consumer must accept.

## Interface
Parameters:
- TLP_MAX_DW, 1024: maximum dwords per TLP; range 2..4096.
- TIMEOUT_CYCLES, 65535: idle clk cycles allowed inside an open TLP before abort; must be ≥1.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  reset; synchronous, active-high.
- din  in  64  command word.
- din_valid  in  1  word strobe; may be high every cycle.
- tlp_dout  out  32  TLP dword (din[63:32]).
- tlp_valid  out  1  TLP dword strobe.
- tlp_first  out  1  first dword of a packet; qualified by tlp_valid.
- tlp_last  out  1  last dword of a packet; qualified by tlp_valid.
- tlp_abort  out  1  one-cycle pulse; the open packet is discarded.
- cfg_dout  out  64  config/DRP word, passed through unchanged.
- cfg_valid  out  1  config strobe.
- cmd_dout  out  64  command-register word, passed through unchanged.
- cmd_valid  out  1  command strobe.
- err_magic  out  1  one-cycle pulse; a word was dropped for bad magic.

## Operation
Word format:
- [7:0] magic; must equal 0x77.
- [9:8] target: 0 = TLP, 1 = CFG, 2 = reserved, 3 = CMD.
- [12] TLP last flag.
- [63:32] TLP data.

Drop rules:
- Word with magic ≠ 0x77: dropped, err_magic pulses, nothing else changes.
- Target 2: dropped silently.

CFG and CMD words:
- Copied to cfg_*/cmd_* respectively.
- Do not affect TLP state; may interleave freely with an open TLP.

TLP framing FSM, two states, IDLE and PKT:
- IDLE + TLP word:
  - tlp_first=1, len=1.
  - If [12]=1: tlp_last=1 and stay in IDLE (single-dword packet).
  - Otherwise: go to PKT.
- PKT + TLP word: len increments.
  - If [12]=1 or len reaches TLP_MAX_DW: tlp_last=1, go to IDLE.
  - Reaching TLP_MAX_DW forces tlp_last even when [12]=0; any further dwords start a new packet.
- PKT, idle counter:
  - Counts up on cycles with no TLP word; clears on every TLP word.
  - When it reaches TIMEOUT_CYCLES: tlp_abort pulses, go to IDLE.
- Timeout and a TLP word in the same cycle: the word wins; no abort.
- len counter width: clog2(TLP_MAX_DW)+1 bits; idle counter width: clog2(TIMEOUT_CYCLES+1) bits. No wrap is possible.

Reset:
- All outputs, FSM (to IDLE) and counters clear to 0 on the cycle after rst is sampled high.
- rst mid-packet drops the packet with no tlp_abort.
- Words presented while rst=1 are ignored.

## Timing
- Every output is registered: exactly 1 clk from din_valid to the corresponding *_valid / err_magic.
- Sustains one word per clk indefinitely.
- Each strobe is high for exactly one cycle per input word.
- Data outputs hold their last value when not valid.
- tlp_abort is asserted in the cycle after the idle counter hits TIMEOUT_CYCLES.
- tlp_abort is never asserted in the same cycle as tlp_valid.

## Configuration
- COM_RX_DISPATCH_STATS_EN defined:
  - Adds outputs stat_tlp_pkts[31:0], stat_aborts[15:0], stat_magic_err[15:0].
  - Counters are saturating, reset to 0 by rst, and update in the same cycle as the corresponding strobe.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- 0x00000003_80182377 valid → 1 clk later cmd_valid=1, cmd_dout equal to the input word; no other strobe.
- TLP words 0xAAAA0001_00000077, 0xBBBB0002_00000077, 0xCCCC0003_00001077 on consecutive clks → tlp_valid ×3 with dout AAAA0001/BBBB0002/CCCC0003, first on word 1, last on word 3; FSM back in IDLE.
- TLP_MAX_DW=4: 6 TLP words, [12]=0 throughout → last on dword 4, first on dword 5; with TIMEOUT_CYCLES=16, tlp_abort pulses 17 clks after dword 6.
- Open TLP, then CFG 0x0100_3F00_0061_2177 and CMD words interleaved, then TLP word with [12]=1 → cfg/cmd pulses in order; the TLP closes with no abort; len counts TLP words only.
- Word 0x12345678_00000066 → err_magic pulse only; open-packet state and idle counter unchanged.
- rst asserted for 1 clk while in PKT → all outputs 0 the next cycle, no tlp_abort; the next TLP word gets tlp_first=1.

Source files
------------

// File: rtl/pcileech_com_rx_dispatch.sv
// Routes 64-bit command words to TLP / CFG / CMD consumers with TLP framing and idle-timeout abort.
// Optional COM_RX_DISPATCH_STATS_EN adds saturating packet/abort/magic-error counters.
module pcileech_com_rx_dispatch #(
   parameter int unsigned TLP_MAX_DW     = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic [31:0] tlp_dout,
   output logic        tlp_valid,
   output logic        tlp_first,
   output logic        tlp_last,
   output logic        tlp_abort,
   output logic [63:0] cfg_dout,
   output logic        cfg_valid,
   output logic [63:0] cmd_dout,
   output logic        cmd_valid,
   output logic        err_magic
`ifdef COM_RX_DISPATCH_STATS_EN
   ,
   output logic [31:0] stat_tlp_pkts,
   output logic [15:0] stat_aborts,
   output logic [15:0] stat_magic_err
`endif
);

   localparam int unsigned LEN_W  = $clog2(TLP_MAX_DW) + 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  MAGIC  = 8'h77;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   w_len_nx;
   logic [LEN_W-1:0]   w_len_inc;
   logic [IDLE_W-1:0]  r_idle;
   logic [IDLE_W-1:0]  w_idle_nx;

   logic w_magic_ok;
   logic w_bad_magic;
   logic w_is_tlp;
   logic w_is_cfg;
   logic w_is_cmd;
   logic w_first;
   logic w_last;
   logic w_abort;

   assign w_magic_ok  = (din[7:0] == MAGIC);
   assign w_bad_magic = din_valid && !w_magic_ok;
   assign w_is_tlp    = din_valid && w_magic_ok && (din[9:8] == 2'd0);
   assign w_is_cfg    = din_valid && w_magic_ok && (din[9:8] == 2'd1);
   assign w_is_cmd    = din_valid && w_magic_ok && (din[9:8] == 2'd3);
   assign w_len_inc   = r_len + LEN_W'(1);

   // Framing state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_idle  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_len   <= w_len_nx;
         r_idle  <= w_idle_nx;
      end
   end

   // Next-state and framing flags; a bad-magic cycle freezes the idle counter and timeout
   always_comb begin
      w_state_nx = r_state;
      w_len_nx   = r_len;
      w_idle_nx  = r_idle;
      w_first    = 1'b0;
      w_last     = 1'b0;
      w_abort    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_tlp) begin
               w_first   = 1'b1;
               w_len_nx  = LEN_W'(1);
               w_idle_nx = '0;
               if (din[12]) begin
                  w_last = 1'b1;
               end else begin
                  w_state_nx = S_PKT;
               end
            end
         end
         S_PKT: begin
            if (w_is_tlp) begin
               w_len_nx  = w_len_inc;
               w_idle_nx = '0;
               if (din[12] || (w_len_inc == LEN_W'(TLP_MAX_DW))) begin
                  w_last     = 1'b1;
                  w_state_nx = S_IDLE;
               end
            end else if (!w_bad_magic) begin
               if (r_idle == IDLE_W'(TIMEOUT_CYCLES)) begin
                  w_abort    = 1'b1;
                  w_idle_nx  = '0;
                  w_state_nx = S_IDLE;
               end else begin
                  w_idle_nx = r_idle + IDLE_W'(1);
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Registered outputs; data holds between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         tlp_dout  <= '0;
         tlp_valid <= 1'b0;
         tlp_first <= 1'b0;
         tlp_last  <= 1'b0;
         tlp_abort <= 1'b0;
         cfg_dout  <= '0;
         cfg_valid <= 1'b0;
         cmd_dout  <= '0;
         cmd_valid <= 1'b0;
         err_magic <= 1'b0;
      end else begin
         tlp_valid <= w_is_tlp;
         tlp_first <= w_first;
         tlp_last  <= w_last;
         tlp_abort <= w_abort;
         cfg_valid <= w_is_cfg;
         cmd_valid <= w_is_cmd;
         err_magic <= w_bad_magic;
         if (w_is_tlp) begin
            tlp_dout <= din[63:32];
         end
         if (w_is_cfg) begin
            cfg_dout <= din;
         end
         if (w_is_cmd) begin
            cmd_dout <= din;
         end
      end
   end

`ifdef COM_RX_DISPATCH_STATS_EN
   // Saturating counters, updated on the same edge as their strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_tlp_pkts  <= '0;
         stat_aborts    <= '0;
         stat_magic_err <= '0;
      end else begin
         if (w_last && (stat_tlp_pkts != 32'hFFFF_FFFF)) begin
            stat_tlp_pkts <= stat_tlp_pkts + 32'd1;
         end
         if (w_abort && (stat_aborts != 16'hFFFF)) begin
            stat_aborts <= stat_aborts + 16'd1;
         end
         if (w_bad_magic && (stat_magic_err != 16'hFFFF)) begin
            stat_magic_err <= stat_magic_err + 16'd1;
         end
      end
   end
`endif

endmodule
